fused_window_pipe: RTL and testbench



---
 rtl/fused_window_pipe.sv | 140 ++++++++++++++
 tb/tb_fused_window_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fused_window_pipe.sv
// Fused two-stage sliding-window pipe: a windowed sum (stage 1) feeds a windowed max (stage 2)
// in one pass over an input memory, writing results to an output memory with sink backpressure.
module fused_window_pipe #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = 6,
   parameter int WIN    = 2,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tstart,
   output logic [AW-1:0]    in_addr,
   output logic             in_rd_en,
   input  logic [WIDTH-1:0] in_rd_data,
   output logic [AW-1:0]    out_addr,
   output logic             out_wr_en,
   output logic [WIDTH-1:0] out_wr_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             tdone
);

   if ((1 << AW) < DEPTH) begin : g_aw_check
      $error("fused_window_pipe: 2**AW must be at least DEPTH");
   end
   if (WIN < 2 || WIN > 4) begin : g_win_check
      $error("fused_window_pipe: WIN must be in 2..4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [AW-1:0] FIRST_WRITE = AW'(2 * (WIN - 1));

   state_t            state, state_next;
   logic [AW-1:0]     rd_cnt, proc_cnt;
   logic              rd_valid, skid_valid;
   logic [WIDTH-1:0]  skid_data;
   logic [WIDTH-1:0]  x_hist [WIN-1];
   logic [WIDTH-1:0]  y_hist [WIN-1];
   logic              start, src_valid, out_free, advance, last_write;
   logic [WIDTH-1:0]  src_data, y1, y2;

   function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      else             return a > b;
   endfunction

   // A word is consumed from the skid register first, otherwise straight off the read bus.
   assign start      = (state == IDLE) && tstart;
   assign in_rd_en   = (state == RUN) && out_ready;
   assign in_addr    = rd_cnt;
   assign busy       = (state != IDLE);
   assign tdone      = (state == DONE);
   assign src_valid  = skid_valid || rd_valid;
   assign src_data   = skid_valid ? skid_data : in_rd_data;
   assign out_free   = !out_wr_en || out_ready;
   assign advance    = src_valid && out_free;
   assign last_write = out_wr_en && out_ready && (out_addr == LAST_ADDR);

   always_comb begin
      y1 = src_data;
      for (int k = 0; k < WIN - 1; k++) y1 = y1 + x_hist[k];
      y2 = y1;
      for (int k = 0; k < WIN - 1; k++) begin
         if (greater(y_hist[k], y2)) y2 = y_hist[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tstart) state_next = RUN;
         RUN:     if (in_rd_en && (rd_cnt == LAST_ADDR)) state_next = DRAIN;
         DRAIN:   if (last_write) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reads are only issued while the sink is ready, so at most one response can land in a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt      <= '0;
         proc_cnt    <= '0;
         rd_valid    <= 1'b0;
         skid_valid  <= 1'b0;
         skid_data   <= '0;
         out_wr_en   <= 1'b0;
         out_addr    <= '0;
         out_wr_data <= '0;
         for (int k = 0; k < WIN - 1; k++) begin
            x_hist[k] <= '0;
            y_hist[k] <= '0;
         end
      end else if (start) begin
         rd_cnt     <= '0;
         proc_cnt   <= '0;
         rd_valid   <= 1'b0;
         skid_valid <= 1'b0;
         out_wr_en  <= 1'b0;
         for (int k = 0; k < WIN - 1; k++) begin
            x_hist[k] <= '0;
            y_hist[k] <= '0;
         end
      end else begin
         rd_valid <= in_rd_en;
         if (in_rd_en) rd_cnt <= rd_cnt + 1'b1;
         if (advance) begin
            proc_cnt    <= proc_cnt + 1'b1;
            out_wr_en   <= (proc_cnt >= FIRST_WRITE);
            out_addr    <= proc_cnt;
            out_wr_data <= y2;
            x_hist[0]   <= src_data;
            y_hist[0]   <= y1;
            for (int k = 1; k < WIN - 1; k++) begin
               x_hist[k] <= x_hist[k-1];
               y_hist[k] <= y_hist[k-1];
            end
            if (skid_valid) begin
               skid_valid <= rd_valid;
               skid_data  <= in_rd_data;
            end
         end else begin
            if (rd_valid) begin
               skid_valid <= 1'b1;
               skid_data  <= in_rd_data;
            end
            if (out_ready) out_wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fused_window_pipe.sv
// Self-checking bench: two instances (WIN=2 unsigned, WIN=3 signed) share one input image and
// sink, and are compared against a window-sum/window-max model plus cycle-timing expectations.
module tb_fused_window_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst_n, tstart, out_ready;

   logic [AW-1:0]    in_addr_a, out_addr_a, in_addr_b, out_addr_b;
   logic             in_rd_en_a, out_wr_en_a, busy_a, tdone_a;
   logic             in_rd_en_b, out_wr_en_b, busy_b, tdone_b;
   logic [WIDTH-1:0] in_rd_data_a, out_wr_data_a, in_rd_data_b, out_wr_data_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] mem_in [DEPTH];
   int          win_of [2] = '{2, 3};
   int          sgn_of [2] = '{0, 1};

   int          exp_rd [2];
   int          exp_wr [2];
   int          done_cnt [2];
   int          done_cyc [2];
   int          wr_total [2];
   logic [31:0] got_data [2][DEPTH];
   int          got_cyc [2][DEPTH];
   bit          prev_stall [2];
   logic [31:0] prev_addr [2];
   logic [31:0] prev_data [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fused_window_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .WIN(2), .SIGNED(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .tstart(tstart),
      .in_addr(in_addr_a), .in_rd_en(in_rd_en_a), .in_rd_data(in_rd_data_a),
      .out_addr(out_addr_a), .out_wr_en(out_wr_en_a), .out_wr_data(out_wr_data_a),
      .out_ready(out_ready), .busy(busy_a), .tdone(tdone_a));

   fused_window_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .WIN(3), .SIGNED(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .tstart(tstart),
      .in_addr(in_addr_b), .in_rd_en(in_rd_en_b), .in_rd_data(in_rd_data_b),
      .out_addr(out_addr_b), .out_wr_en(out_wr_en_b), .out_wr_data(out_wr_data_b),
      .out_ready(out_ready), .busy(busy_b), .tdone(tdone_b));

   // Input memories: one-cycle read latency; garbage on the bus when no read was issued.
   always @(posedge clk) begin
      in_rd_data_a <= in_rd_en_a ? mem_in[in_addr_a] : 32'hDEAD_BEEF;
      in_rd_data_b <= in_rd_en_b ? mem_in[in_addr_b] : 32'hBADC_0FFE;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit isGreater(input logic [31:0] a, input logic [31:0] b, input int sgn);
      if (sgn != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   // y2[j] = max over k of y1[j-k], y1[i] = sum over m of in[i-m]
   function automatic logic [31:0] refY2(input int win, input int sgn, input int j);
      logic [31:0] best, y;
      best = '0;
      for (int k = 0; k < win; k++) begin
         y = '0;
         for (int m = 0; m < win; m++) y = y + mem_in[j-k-m];
         if (k == 0 || isGreater(y, best, sgn)) best = y;
      end
      return best;
   endfunction

   task automatic monitorStep(input int k, input logic rd_en, input logic [AW-1:0] rd_addr,
                              input logic wr, input logic [AW-1:0] addr,
                              input logic [31:0] data, input logic done);
      if (rd_en) begin
         checkOutput($sformatf("rd_addr_%0d", k), 32'(rd_addr), 32'(exp_rd[k]));
         checkOutput($sformatf("rd_in_stall_%0d", k), 32'(out_ready), 32'd1);
         exp_rd[k]++;
      end
      if (prev_stall[k]) begin
         checkOutput($sformatf("hold_en_%0d", k), 32'(wr), 32'd1);
         checkOutput($sformatf("hold_addr_%0d", k), 32'(addr), prev_addr[k]);
         checkOutput($sformatf("hold_data_%0d", k), data, prev_data[k]);
      end
      prev_stall[k] = wr && !out_ready;
      prev_addr[k]  = 32'(addr);
      prev_data[k]  = data;
      if (wr && out_ready) begin
         checkOutput($sformatf("wr_addr_%0d", k), 32'(addr), 32'(exp_wr[k]));
         exp_wr[k]++;
         got_data[k][addr] = data;
         got_cyc[k][addr]  = cyc;
         wr_total[k]++;
      end
      if (done) begin
         done_cnt[k]++;
         done_cyc[k] = cyc;
      end
   endtask

   always @(negedge clk) begin
      monitorStep(0, in_rd_en_a, in_addr_a, out_wr_en_a, out_addr_a, out_wr_data_a, tdone_a);
      monitorStep(1, in_rd_en_b, in_addr_b, out_wr_en_b, out_addr_b, out_wr_data_b, tdone_b);
   end

   task automatic clearMonitor();
      for (int k = 0; k < 2; k++) begin
         exp_rd[k]     = 0;
         exp_wr[k]     = 2 * (win_of[k] - 1);
         done_cnt[k]   = 0;
         done_cyc[k]   = -1;
         wr_total[k]   = 0;
         prev_stall[k] = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            got_data[k][j] = 'x;
            got_cyc[k][j]  = -1;
         end
      end
   endtask

   // rmode 0: out_ready low for stall_len cycles from t0+stall_at; rmode 1: random out_ready.
   task automatic applyStimulus(input int rmode, input int stall_at, input int stall_len,
                                input bit extra_pulse, output int t0);
      bit finished;
      finished = 1'b0;
      clearMonitor();
      @(posedge clk); #1;
      tstart = 1'b1;
      out_ready = 1'b1;
      t0 = cyc;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         tstart = extra_pulse && (cyc - t0 == 4);
         if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = !((cyc - t0 >= stall_at) && (cyc - t0 < stall_at + stall_len));
         if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
            finished = 1'b1;
            break;
         end
      end
      checkOutput("run_finished", 32'(finished), 32'd1);
      tstart = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic verifyRun(input int t0, input bit timing, input int exp_done);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("rd_count_%0d", k), 32'(exp_rd[k]), 32'(DEPTH));
         checkOutput($sformatf("wr_count_%0d", k), 32'(wr_total[k]), 32'(DEPTH - 2 * (win_of[k] - 1)));
         checkOutput($sformatf("done_count_%0d", k), 32'(done_cnt[k]), 32'd1);
         if (exp_done >= 0)
            checkOutput($sformatf("done_cycle_%0d", k), 32'(done_cyc[k] - t0), 32'(exp_done));
         for (int j = 2 * (win_of[k] - 1); j < DEPTH; j++) begin
            checkOutput($sformatf("wr_data_%0d_a%0d", k, j), got_data[k][j], refY2(win_of[k], sgn_of[k], j));
            if (timing)
               checkOutput($sformatf("wr_cycle_%0d_a%0d", k, j), 32'(got_cyc[k][j] - t0), 32'(3 + j));
         end
      end
   endtask

   initial begin
      int t0, snap;
      rst_n = 1'b0;
      tstart = 1'b0;
      out_ready = 1'b1;
      clearMonitor();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_tdone", 32'(tdone_a), 32'd0);
      checkOutput("rst_rd_en", 32'(in_rd_en_a), 32'd0);
      checkOutput("rst_wr_en", 32'(out_wr_en_a), 32'd0);
      checkOutput("rst_in_addr", 32'(in_addr_a), 32'd0);
      checkOutput("rst_out_addr", 32'(out_addr_a), 32'd0);
      checkOutput("rst_out_data", out_wr_data_a, 32'd0);
      checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Ramp input: 3,5,...,13 at addresses 2..7
      for (int i = 0; i < DEPTH; i++) mem_in[i] = 32'(i);
      applyStimulus(0, 0, 0, 1'b0, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);
      checkOutput("ramp_a2", got_data[0][2], 32'd3);
      checkOutput("ramp_a7", got_data[0][7], 32'd13);
      checkOutput("busy_during", 32'(busy_a), 32'd0);

      for (int i = 0; i < DEPTH; i++) mem_in[i] = (i % 2 == 0) ? 32'd10 : 32'd0;
      applyStimulus(0, 0, 0, 1'b0, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);
      for (int j = 2; j < DEPTH; j++) checkOutput($sformatf("alt10_a%0d", j), got_data[0][j], 32'd10);

      for (int i = 0; i < DEPTH; i++) mem_in[i] = 32'hFFFF_FFFF;
      applyStimulus(0, 0, 0, 1'b0, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);
      checkOutput("neg_sum_a4", got_data[1][4], 32'hFFFF_FFFD);
      checkOutput("neg_sum_a7", got_data[1][7], 32'hFFFF_FFFD);

      for (int i = 0; i < DEPTH; i++) mem_in[i] = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0001;
      applyStimulus(0, 0, 0, 1'b0, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);
      checkOutput("uns_a3", got_data[0][3], 32'h8000_0001);
      checkOutput("uns_a6", got_data[0][6], 32'h8000_0001);

      // Three-cycle sink stall starting at t0+6
      for (int i = 0; i < DEPTH; i++) mem_in[i] = 32'(i);
      applyStimulus(0, 6, 3, 1'b0, t0);
      verifyRun(t0, 1'b0, DEPTH + 6);

      // Reset in the middle of a run, then a clean second run
      clearMonitor();
      @(posedge clk); #1;
      tstart = 1'b1;
      t0 = cyc;
      while (cyc - t0 < 6) begin
         @(posedge clk); #1;
         tstart = 1'b0;
      end
      rst_n = 1'b0;
      snap = wr_total[0];
      checkOutput("abort_pre_writes", 32'(snap), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("abort_writes_a", 32'(wr_total[0]), 32'(snap));
      checkOutput("abort_writes_b", 32'(wr_total[1]), 32'd0);
      checkOutput("abort_tdone_a", 32'(done_cnt[0]), 32'd0);
      checkOutput("abort_tdone_b", 32'(done_cnt[1]), 32'd0);
      applyStimulus(0, 0, 0, 1'b0, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);

      // Stray tstart while running
      applyStimulus(0, 0, 0, 1'b1, t0);
      verifyRun(t0, 1'b1, DEPTH + 3);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_in[i] = $urandom;
            if (r % 2 == 1) mem_in[i][31] = 1'b1;
         end
         applyStimulus(1, 0, 0, 1'b0, t0);
         verifyRun(t0, 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
